// File: rtl/press_counter_7seg.sv
// rtl/press_counter_7seg.sv - two-digit BCD up/down press counter with auto-repeat and 7-seg outputs
// Optional macro PRESS_COUNTER_BLANK_EN: blank the tens digit when it is zero.
module press_counter_7seg #(
  parameter int HOLD_CYCLES   = 12500000,
  parameter int REPEAT_CYCLES = 2500000,
  parameter int CTR_WIDTH     = 24
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_clr,
  output logic [7:0] o_count,
  output logic [6:0] o_seg1,
  output logic [6:0] o_seg2
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  localparam logic [CTR_WIDTH-1:0] HOLD_LAST   = CTR_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CTR_WIDTH-1:0] REPEAT_LAST = CTR_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [6:0]           SEG_ZERO    = 7'b1000000;
  localparam logic [6:0]           SEG_OFF     = 7'b1111111;

  state_t               r_state;
  logic                 r_dir;
  logic [CTR_WIDTH-1:0] r_timer;
  logic [7:0]           r_count;
  logic                 r_inc_prev;
  logic                 r_dec_prev;
  logic [6:0]           r_seg1;
  logic [6:0]           r_seg2;

  logic                 w_inc_edge;
  logic                 w_dec_edge;
  logic                 w_abort;
  logic [CTR_WIDTH-1:0] w_limit;

  function automatic logic [7:0] bcd_step(input logic [7:0] c, input logic up);
    logic [3:0] t;
    logic [3:0] u;
    t = c[7:4];
    u = c[3:0];
    if (up) begin
      if (u == 4'd9) begin
        u = 4'd0;
        t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
        u = u + 4'd1;
      end
    end else begin
      if (u == 4'd0) begin
        u = 4'd9;
        t = (t == 4'd0) ? 4'd9 : t - 4'd1;
      end else begin
        u = u - 4'd1;
      end
    end
    return {t, u};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  assign w_inc_edge = i_inc & ~r_inc_prev;
  assign w_dec_edge = i_dec & ~r_dec_prev;
  // Releasing the latched button or touching the other one cancels the hold.
  assign w_abort    = r_dir ? (~i_inc | i_dec) : (~i_dec | i_inc);
  assign w_limit    = (r_state == S_HOLD) ? HOLD_LAST : REPEAT_LAST;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_timer    <= '0;
      r_count    <= 8'h00;
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
    end else begin
      r_inc_prev <= i_inc;
      r_dec_prev <= i_dec;
      if (i_clr) begin
        r_count <= 8'h00;
        r_state <= S_IDLE;
        r_timer <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_inc_edge && !i_dec) begin
              r_count <= bcd_step(r_count, 1'b1);
              r_dir   <= 1'b1;
              r_timer <= '0;
              r_state <= S_HOLD;
            end else if (w_dec_edge && !i_inc) begin
              r_count <= bcd_step(r_count, 1'b0);
              r_dir   <= 1'b0;
              r_timer <= '0;
              r_state <= S_HOLD;
            end
          end
          S_HOLD, S_REPEAT: begin
            if (w_abort) begin
              r_state <= S_IDLE;
              r_timer <= '0;
            end else if (r_timer == w_limit) begin
              r_count <= bcd_step(r_count, r_dir);
              r_timer <= '0;
              r_state <= S_REPEAT;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
`ifdef PRESS_COUNTER_BLANK_EN
      r_seg1 <= SEG_OFF;
`else
      r_seg1 <= SEG_ZERO;
`endif
      r_seg2 <= SEG_ZERO;
    end else begin
`ifdef PRESS_COUNTER_BLANK_EN
      r_seg1 <= (r_count[7:4] == 4'd0) ? SEG_OFF : seg_decode(r_count[7:4]);
`else
      r_seg1 <= seg_decode(r_count[7:4]);
`endif
      r_seg2 <= seg_decode(r_count[3:0]);
    end
  end

  assign o_count = r_count;
  assign o_seg1  = r_seg1;
  assign o_seg2  = r_seg2;

endmodule

// File: tb/tb_press_counter_7seg.sv
// tb/tb_press_counter_7seg.sv - directed and random bench for press_counter_7seg against a behavioural model
module tb_press_counter_7seg;

  localparam int H = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] count;
  logic [6:0] seg1;
  logic [6:0] seg2;

  int checks = 0;
  int errors = 0;

  // Behavioural model: count as an integer 0..99, hold tracked as age since press.
  int m_count = 0;
  int m_shown = 0;
  bit m_active = 0;
  bit m_up = 0;
  int m_age = 0;
  bit m_pinc = 0;
  bit m_pdec = 0;

  logic [6:0] seg_tab [10];

  press_counter_7seg #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CTR_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_dec(dec), .i_clr(clr),
    .o_count(count), .o_seg1(seg1), .o_seg2(seg2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_tens(input int v);
`ifdef PRESS_COUNTER_BLANK_EN
    if (v / 10 == 0) return 7'b1111111;
`endif
    return seg_tab[v / 10];
  endfunction

  function automatic int stepped(input int v, input bit up);
    return up ? (v + 1) % 100 : (v + 99) % 100;
  endfunction

  task automatic model_edge();
    bit ie;
    bit de;
    ie = inc && !m_pinc;
    de = dec && !m_pdec;
    if (clr) begin
      m_count  = 0;
      m_active = 0;
    end else if (m_active) begin
      if (m_up ? (!inc || dec) : (!dec || inc)) begin
        m_active = 0;
      end else begin
        m_age++;
        if (m_age == H || (m_age > H && (m_age - H) % R == 0))
          m_count = stepped(m_count, m_up);
      end
    end else if (ie && !dec) begin
      m_count = stepped(m_count, 1); m_active = 1; m_up = 1; m_age = 0;
    end else if (de && !inc) begin
      m_count = stepped(m_count, 0); m_active = 1; m_up = 0; m_age = 0;
    end
    m_pinc = inc;
    m_pdec = dec;
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, model the rising edge, check at the next falling edge.
  task automatic cyc(input bit i, input bit d, input bit c);
    inc = i; dec = d; clr = c;
    @(posedge clk);
    m_shown = m_count;
    model_edge();
    @(negedge clk);
    check8("count", count, to_bcd(m_count));
    check8("seg1", {1'b0, seg1}, {1'b0, exp_tens(m_shown)});
    check8("seg2", {1'b0, seg2}, {1'b0, seg_tab[m_shown % 10]});
  endtask

  task automatic model_reset();
    m_count = 0; m_shown = 0; m_active = 0; m_age = 0; m_pinc = 0; m_pdec = 0;
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    repeat (2) @(negedge clk);
    check8("rst_count", count, 8'h00);
`ifdef PRESS_COUNTER_BLANK_EN
    check8("rst_seg1", {1'b0, seg1}, 8'h7f);
`else
    check8("rst_seg1", {1'b0, seg1}, 8'h40);
`endif
    check8("rst_seg2", {1'b0, seg2}, 8'h40);
    rst = 1'b0;
    cyc(0, 0, 0);

    for (int k = 0; k < 12; k++) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    check8("twelve", count, 8'h12);
    cyc(0, 0, 0);
    check8("twelve_seg1", {1'b0, seg1}, 8'h79);
    check8("twelve_seg2", {1'b0, seg2}, 8'h24);

    cyc(0, 0, 1);
    cyc(0, 1, 0); cyc(0, 0, 0);
    check8("wrap_down", count, 8'h99);
    cyc(1, 0, 0); cyc(0, 0, 0);
    check8("wrap_up", count, 8'h00);

    for (int k = 0; k <= 20; k++) cyc(1, 0, 0);
    check8("hold20", count, 8'h05);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0);
    check8("released", count, 8'h05);

    cyc(1, 1, 0); cyc(1, 1, 0); cyc(0, 0, 0);
    check8("both_edge", count, 8'h05);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    for (int k = 0; k < 15; k++) cyc(1, 0, 0);
    check8("dec_abort", count, 8'h06);
    cyc(0, 0, 0);

    for (int k = 0; k < 14; k++) cyc(1, 0, 0);
    cyc(1, 0, 1); cyc(1, 0, 1);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0);
    check8("clr_held", count, 8'h00);
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    check8("clr_repress", count, 8'h01);

    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50) cyc(inc, dec, 0);
      else if (r < 72) cyc(~inc, dec, 0);
      else if (r < 90) cyc(inc, ~dec, 0);
      else if (r < 97) cyc(0, 0, 0);
      else cyc(inc, dec, 1);
    end

    cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check8("async_count", count, 8'h00);
`ifdef PRESS_COUNTER_BLANK_EN
    check8("async_seg1", {1'b0, seg1}, 8'h7f);
`else
    check8("async_seg1", {1'b0, seg1}, 8'h40);
`endif
    check8("async_seg2", {1'b0, seg2}, 8'h40);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    check8("post_rst", count, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/press_counter_7seg.md
Name: press_counter_7seg

Overview:
Downstream consumer of the per-switch debounce stage. Takes two debounced switch levels (increment, decrement) and keeps a two-digit BCD count 00..99. Holding a button auto-repeats. Drives the two active-low seven-segment digits on the board top.

Parameters:
HOLD_CYCLES, 12500000, cycles a single button must stay held after the press step before the first auto-repeat step (0.5 s at 25 MHz); legal range 2..2^CTR_WIDTH.
REPEAT_CYCLES, 2500000, cycles between auto-repeat steps (0.1 s at 25 MHz); legal range 2..2^CTR_WIDTH.
CTR_WIDTH, 24, width of the hold/repeat timer.

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_inc  input  1  debounced increment switch, 1 = pressed
i_dec  input  1  debounced decrement switch, 1 = pressed
i_clr  input  1  synchronous clear of the count, level-sensitive
o_count  output  8  BCD count, [7:4] tens, [3:0] units
o_seg1  output  7  tens digit, active-low, bit order {g,f,e,d,c,b,a}
o_seg2  output  7  units digit, active-low, bit order {g,f,e,d,c,b,a}

Behaviour:
- Reset (async, active-high): count = 00; FSM = S_IDLE; timer = 0; previous-sample registers = 0; o_seg1 = o_seg2 = 7'b1000000, which displays "0".
- Press edge: the input is 1 now and its registered previous sample is 0.
- Step: +1 or -1 in BCD.
  - 99+1 wraps to 00; 00-1 wraps to 99.
  - Units carry/borrow into tens. Count never holds a non-BCD nibble.
- Latency: a step occurs on the clock edge that samples the press edge. o_count is valid 1 cycle later. o_seg1/o_seg2 are registered decodes of the count, valid 2 cycles after the sampling edge.
- FSM:
  - S_IDLE:
    - Press edge on exactly one input with the other input 0: step in that direction, latch the direction, clear the timer, go to S_HOLD.
    - Press edges on both inputs in the same cycle: no step, stay in S_IDLE.
  - S_HOLD:
    - Timer increments each cycle.
    - Latched input goes 0, or the other input goes 1: go to S_IDLE, no step.
    - Timer == HOLD_CYCLES-1 while held: step, clear the timer, go to S_REPEAT.
  - S_REPEAT:
    - Same abort rule as S_HOLD.
    - Timer == REPEAT_CYCLES-1: step and clear the timer; wrap rule applies during repeat.
- i_clr has the highest priority below reset. While i_clr is 1:
  - count <= 00, FSM <= S_IDLE, timer <= 0, no step.
  - Previous-sample registers still update, so a button held through the clear does not step until it is released and pressed again.
- After returning to S_IDLE, a button still held from before does not step.
- Segment decode: standard 0-9 patterns, active-low. The count is always BCD, so no other codes occur.

Optional Feature:
PRESS_COUNTER_BLANK_EN
- Defined: leading-zero blanking. When the tens nibble is 0, o_seg1 = 7'b1111111 (all off). After reset o_seg1 = 7'b1111111 and o_seg2 = 7'b1000000. o_count is unaffected.
- Undefined: the tens digit always shows its numeral, including "0".

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4):
- Reset released, no input -> o_count=8'h00; o_seg1=o_seg2=7'b1000000; without the macro, o_seg1=7'b1111111 with it.
- i_inc pulsed high 1 cycle, 12 times -> o_count=8'h12; o_seg1=7'b1111001, o_seg2=7'b0100100.
- Count 8'h00, i_dec pulsed 1 cycle -> 8'h99. Then i_inc pulsed 1 cycle -> 8'h00 (wrap both ways).
- i_inc held 20 cycles from count 8'h00:
  - step at the press (8'h01), step at +8 cycles (8'h02), then every 4 cycles;
  - final 8'h05 (steps at sampling cycles 0, 8, 12, 16, 20);
  - release -> no further steps.
- i_inc and i_dec rise in the same cycle -> count unchanged. i_dec pressed while i_inc held in S_HOLD -> FSM to S_IDLE, no step.
- Edge cases -> reset and clear behave exactly as above:
  - i_clr asserted during S_REPEAT with i_inc still held -> count 8'h00, no steps until i_inc falls and rises again.
  - i_rst asserted mid-cycle -> outputs reset immediately, without waiting for a clock edge.
